// File: rtl/conv_stream_feeder_pkg.sv
// Shared types for the stream feeder: FSM states and channel identifiers.
package conv_stream_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_t;

endpackage

// File: rtl/conv_stream_feeder_fifo.sv
// Small synchronous FIFO with occupancy count; one per output channel.
module stream_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [OW-1:0]    occ
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (occ == OW'(DEPTH));
    assign empty   = (occ == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rd_ptr];

    // Data storage; contents are never observed while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping; push+pop leaves occupancy unchanged.
    always_ff @(posedge clk) begin
        if (srst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/conv_stream_feeder.sv
// Fetches A and B word streams from a shared 1-cycle-latency memory port
// and presents them on two valid/ready outputs through small FIFOs.
module conv_stream_feeder
    import conv_stream_feeder_pkg::*;
#(
    parameter int IO_DATA_WIDTH  = 16,
    parameter int EXT_MEM_HEIGHT = 1 << 20,
    parameter int FIFO_DEPTH     = 4,
    localparam int AW            = $clog2(EXT_MEM_HEIGHT)
) (
    input  logic                     clk,
    input  logic                     srst_in,
    input  logic                     start,
    input  logic [AW-1:0]            a_base,
    input  logic [AW-1:0]            b_base,
    input  logic [AW:0]              a_count,
    input  logic [AW:0]              b_count,
    output logic [AW-1:0]            mem_read_addr,
    output logic                     mem_read_en,
    input  logic [IO_DATA_WIDTH-1:0] mem_qout,
    output logic [IO_DATA_WIDTH-1:0] a_output,
    output logic                     a_valid,
    input  logic                     a_ready,
    output logic [IO_DATA_WIDTH-1:0] b_output,
    output logic                     b_valid,
    input  logic                     b_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int OW = $clog2(FIFO_DEPTH + 1);

    state_t                   state;
    logic [AW-1:0]            base_q   [2];
    logic [AW-1:0]            issued_q [2];
    logic [AW:0]              rem_q    [2];
    logic                     rd_pend;
    chan_t                    rd_tag;
    chan_t                    rr_ptr;

    logic [1:0]               elig, push, pop, empty, full, rdy;
    logic [OW-1:0]            occ  [2];
    logic [IO_DATA_WIDTH-1:0] head [2];
    logic                     grant_vld, gsel, drained;
    chan_t                    grant_ch;

    assign rdy = {b_ready, a_ready};

    // Returning read data belongs to whichever channel was granted last cycle.
    assign push[0] = rd_pend && (rd_tag == CH_A);
    assign push[1] = rd_pend && (rd_tag == CH_B);

    for (genvar i = 0; i < 2; i++) begin : g_ch
        stream_fifo #(.WIDTH(IO_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .srst_in (srst_in),
            .push    (push[i]),
            .din     (mem_qout),
            .pop     (pop[i]),
            .dout    (head[i]),
            .full    (full[i]),
            .empty   (empty[i]),
            .occ     (occ[i])
        );
        assign pop[i] = !empty[i] && rdy[i];
        // Registered occupancy plus the in-flight word must leave room;
        // a same-cycle pop is deliberately not credited.
        assign elig[i] = (state == RUN) && (rem_q[i] != '0) && !full[i] &&
                         ((32'(occ[i]) + 32'(push[i])) < 32'(FIFO_DEPTH));
    end

    assign a_valid  = !empty[0];
    assign b_valid  = !empty[1];
    assign a_output = empty[0] ? '0 : head[0];
    assign b_output = empty[1] ? '0 : head[1];

    // Finished once nothing is left to fetch, nothing returns, and this
    // cycle's pops empty both FIFOs.
    assign drained = (rem_q[0] == '0) && (rem_q[1] == '0) && !rd_pend &&
                     (32'(occ[0]) == 32'(pop[0])) && (32'(occ[1]) == 32'(pop[1]));

    // Single-read-per-cycle arbiter; round-robin only matters when contested.
    always_comb begin
        grant_vld = |elig;
        grant_ch  = CH_A;
        if (&elig)        grant_ch = rr_ptr;
        else if (elig[1]) grant_ch = CH_B;
        gsel          = (grant_ch == CH_B);
        mem_read_en   = grant_vld;
        mem_read_addr = grant_vld ? base_q[gsel] + issued_q[gsel] : '0;
    end

    // Transfer-level FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (srst_in) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (a_count == '0 && b_count == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: if (drained) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel fetch progress, read tag and arbitration pointer.
    always_ff @(posedge clk) begin
        if (srst_in) begin
            rd_pend <= 1'b0;
            rd_tag  <= CH_A;
            rr_ptr  <= CH_A;
            for (int i = 0; i < 2; i++) begin
                base_q[i]   <= '0;
                issued_q[i] <= '0;
                rem_q[i]    <= '0;
            end
        end else begin
            rd_pend <= grant_vld;
            if (grant_vld) rd_tag <= grant_ch;
            if (grant_vld && (&elig)) rr_ptr <= (grant_ch == CH_A) ? CH_B : CH_A;
            if (state == IDLE && start) begin
                base_q[0]   <= a_base;
                base_q[1]   <= b_base;
                issued_q[0] <= '0;
                issued_q[1] <= '0;
                rem_q[0]    <= a_count;
                rem_q[1]    <= b_count;
            end else if (grant_vld) begin
                issued_q[gsel] <= issued_q[gsel] + 1'b1;
                rem_q[gsel]    <= rem_q[gsel] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed bench for conv_stream_feeder with a behavioural 1-cycle memory.
module tb_conv_stream_feeder;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          clk, srst_in, start;
    logic [AW-1:0] a_base, b_base, mem_read_addr;
    logic [AW:0]   a_count, b_count;
    logic          mem_read_en, a_valid, a_ready, b_valid, b_ready, busy, done;
    logic [DW-1:0] mem_qout, a_output, b_output;

    int n_tests = 0;
    int n_fail  = 0;

    int            rd_cyc[$];
    logic [AW-1:0] rd_addr[$];
    int            pa_cyc[$], pb_cyc[$];
    logic [DW-1:0] pa_dat[$], pb_dat[$];
    int            busy_n, stall_rd, done_cyc;

    conv_stream_feeder #(.IO_DATA_WIDTH(DW), .EXT_MEM_HEIGHT(1 << AW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .srst_in(srst_in), .start(start),
        .a_base(a_base), .b_base(b_base), .a_count(a_count), .b_count(b_count),
        .mem_read_addr(mem_read_addr), .mem_read_en(mem_read_en), .mem_qout(mem_qout),
        .a_output(a_output), .a_valid(a_valid), .a_ready(a_ready),
        .b_output(b_output), .b_valid(b_valid), .b_ready(b_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mf(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // Memory model: data appears the cycle after the read strobe.
    always @(posedge clk) if (mem_read_en) mem_qout <= mf(mem_read_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        srst_in = 1'b1; start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        repeat (2) @(negedge clk);
        srst_in = 1'b0;
    endtask

    // Start a transfer and log reads/pops per cycle (cycle 1 = first after start edge).
    task automatic run_xfer(input logic [AW-1:0] ab, input int ac,
                            input logic [AW-1:0] bb, input int bc, input int a_stall);
        rd_cyc.delete(); rd_addr.delete();
        pa_cyc.delete(); pa_dat.delete(); pb_cyc.delete(); pb_dat.delete();
        busy_n = 0; stall_rd = 0; done_cyc = -1;
        @(negedge clk);
        start = 1'b1; a_base = ab; b_base = bb;
        a_count = (AW+1)'(ac); b_count = (AW+1)'(bc);
        for (int c = 1; c < 200 && done_cyc < 0; c++) begin
            @(negedge clk);
            start   = 1'b0;
            a_ready = (c > a_stall);
            b_ready = 1'b1;
            if (mem_read_en) begin
                rd_cyc.push_back(c); rd_addr.push_back(mem_read_addr);
                if (c <= a_stall) stall_rd++;
            end
            if (a_valid && a_ready) begin pa_cyc.push_back(c); pa_dat.push_back(a_output); end
            if (b_valid && b_ready) begin pb_cyc.push_back(c); pb_dat.push_back(b_output); end
            if (busy) busy_n++;
            if (done) done_cyc = c;
        end
        if (done_cyc < 0) chk("done_timeout", 32'(done_cyc), 32'd0);
    endtask

    initial begin
        srst_in = 1'b1; start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        a_base = '0; b_base = '0; a_count = '0; b_count = '0; mem_qout = '0;
        do_reset();

        // Reset state
        chk("rst_en",    32'(mem_read_en),   32'd0);
        chk("rst_addr",  32'(mem_read_addr), 32'd0);
        chk("rst_valid", 32'({a_valid, b_valid}), 32'd0);
        chk("rst_data",  32'({a_output, b_output}), 32'd0);
        chk("rst_stat",  32'({busy, done}), 32'd0);

        // Single A channel: latency and throughput
        run_xfer(20'h10, 4, 20'h0, 0, 0);
        chk("t1_nrd", 32'(rd_cyc.size()), 32'd4);
        chk("t1_npop", 32'(pa_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < rd_cyc.size(); i++) begin
            chk("t1_rdcyc", 32'(rd_cyc[i]), 32'(i + 1));
            chk("t1_rdaddr", 32'(rd_addr[i]), 32'(20'h10 + i));
        end
        for (int i = 0; i < 4 && i < pa_cyc.size(); i++) begin
            chk("t1_popcyc", 32'(pa_cyc[i]), 32'(i + 3));
            chk("t1_popdat", 32'(pa_dat[i]), 32'(mf(20'(20'h10 + i))));
        end
        chk("t1_done", 32'(done_cyc), 32'd7);
        chk("t1_busy", 32'(busy_n), 32'd6);
        chk("t1_bpop", 32'(pb_cyc.size()), 32'd0);

        // Both channels contested: strict alternation
        do_reset();
        run_xfer(20'h100, 3, 20'h200, 3, 0);
        chk("t2_nrd", 32'(rd_addr.size()), 32'd6);
        for (int i = 0; i < 6 && i < rd_addr.size(); i++)
            chk("t2_rdaddr", 32'(rd_addr[i]), (i % 2 == 0) ? 32'(20'h100 + i / 2) : 32'(20'h200 + i / 2));
        chk("t2_napop", 32'(pa_dat.size()), 32'd3);
        chk("t2_nbpop", 32'(pb_dat.size()), 32'd3);
        for (int i = 0; i < 3 && i < pa_dat.size(); i++)
            chk("t2_adat", 32'(pa_dat[i]), 32'(mf(20'(20'h100 + i))));
        for (int i = 0; i < 3 && i < pb_dat.size(); i++)
            chk("t2_bdat", 32'(pb_dat[i]), 32'(mf(20'(20'h200 + i))));

        // Back-pressure: ready low for 10 cycles
        do_reset();
        run_xfer(20'h40, 8, 20'h0, 0, 10);
        chk("t3_stall_rd", 32'(stall_rd), 32'd4);
        chk("t3_nrd", 32'(rd_addr.size()), 32'd8);
        chk("t3_npop", 32'(pa_dat.size()), 32'd8);
        for (int i = 0; i < 8 && i < pa_dat.size(); i++) begin
            chk("t3_dat", 32'(pa_dat[i]), 32'(mf(20'(20'h40 + i))));
            chk("t3_nogap", 32'(pa_cyc[i]), 32'(11 + i));
        end

        // Address wrap at top of memory
        do_reset();
        run_xfer(20'hFFFFE, 4, 20'h0, 0, 0);
        chk("t4_nrd", 32'(rd_addr.size()), 32'd4);
        if (rd_addr.size() == 4) begin
            chk("t4_a0", 32'(rd_addr[0]), 32'hFFFFE);
            chk("t4_a1", 32'(rd_addr[1]), 32'hFFFFF);
            chk("t4_a2", 32'(rd_addr[2]), 32'h00000);
            chk("t4_a3", 32'(rd_addr[3]), 32'h00001);
        end
        if (pa_dat.size() == 4) begin
            chk("t4_d0", 32'(pa_dat[0]), 32'h5A5B);
            chk("t4_d2", 32'(pa_dat[2]), 32'hA5A5);
        end

        // Zero-length transfer
        do_reset();
        run_xfer(20'h0, 0, 20'h0, 0, 0);
        chk("t5_done", 32'(done_cyc), 32'd1);
        chk("t5_nrd", 32'(rd_addr.size()), 32'd0);
        chk("t5_npop", 32'(pa_cyc.size() + pb_cyc.size()), 32'd0);
        chk("t5_busy", 32'(busy_n), 32'd0);
        @(negedge clk);
        chk("t5_done_low", 32'(done), 32'd0);

        // Reset mid-transfer
        do_reset();
        @(negedge clk);
        start = 1'b1; a_base = 20'h80; a_count = 21'd5; b_count = '0; a_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t6_rd1", 32'(mem_read_en), 32'd1);
        @(negedge clk);
        chk("t6_rd2", 32'(mem_read_en), 32'd1);
        srst_in = 1'b1;
        @(negedge clk);
        chk("t6_rst_en",    32'(mem_read_en),   32'd0);
        chk("t6_rst_addr",  32'(mem_read_addr), 32'd0);
        chk("t6_rst_valid", 32'({a_valid, b_valid}), 32'd0);
        chk("t6_rst_data",  32'({a_output, b_output}), 32'd0);
        chk("t6_rst_stat",  32'({busy, done}), 32'd0);
        srst_in = 1'b0;
        @(negedge clk);
        chk("t6_no_push", 32'(a_valid), 32'd0);
        run_xfer(20'h90, 2, 20'h0, 0, 0);
        chk("t6_npop", 32'(pa_dat.size()), 32'd2);
        if (pa_dat.size() == 2) begin
            chk("t6_d0", 32'(pa_dat[0]), 32'(mf(20'h90)));
            chk("t6_d1", 32'(pa_dat[1]), 32'(mf(20'h91)));
        end
        chk("t6_done", 32'(done_cyc), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
